tristate_nand_cycle_model: RTL and testbench



---
 rtl/tnand_pkg.sv | 42 ++++
 rtl/tristate_nand_cycle_model_mos_inertial_delay.sv | 68 ++++++
 rtl/tristate_nand_cycle_model.sv | 117 +++++++++++
 tb/tb_tristate_nand_cycle_model.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tnand_pkg.sv
// Shared types and default timing for the tri-state NAND cycle model.
// Delays are whole clock cycles; every delay must be at least 1.
package tnand_pkg;

    // Logical state of the output node.
    typedef enum logic [1:0] {
        W_ZERO = 2'd0,
        W_ONE  = 2'd1,
        W_HIZ  = 2'd2
    } w_state_e;

    // Default transistor delays in clock cycles.
    localparam int DEF_P_RISE = 4;
    localparam int DEF_P_FALL = 7;
    localparam int DEF_P_OFF  = 9;
    localparam int DEF_N_RISE = 3;
    localparam int DEF_N_FALL = 5;
    localparam int DEF_N_OFF  = 7;

    // Largest of the six delays; sizes the down-counters.
    function automatic int max_delay(
        input int p_rise,
        input int p_fall,
        input int p_off,
        input int n_rise,
        input int n_fall,
        input int n_off
    );
        int m;
        m = p_rise;
        if (p_fall > m) m = p_fall;
        if (p_off  > m) m = p_off;
        if (n_rise > m) m = n_rise;
        if (n_fall > m) m = n_fall;
        if (n_off  > m) m = n_off;
        return m;
    endfunction

    localparam int DEF_CNT_W = $clog2(max_delay(DEF_P_RISE, DEF_P_FALL, DEF_P_OFF,
                                                DEF_N_RISE, DEF_N_FALL, DEF_N_OFF) + 1);

endpackage

// File: rtl/tristate_nand_cycle_model_mos_inertial_delay.sv
// Generic inertial delay element: a state register that follows its target
// only after the target has been stable for the requested number of edges.
// A target that falls back to the current state cancels the pending change;
// a target that moves to a third value restarts the count with the new delay.
module mos_inertial_delay #(
    parameter int             W           = 1,
    parameter int             CW          = 4,
    parameter logic [W-1:0]   RESET_STATE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  target,
    input  logic [CW-1:0] delay,
    output logic [W-1:0]  state,
    output logic [W-1:0]  next_state
);

    logic [W-1:0]  state_reg;
    logic [W-1:0]  state_next;
    logic          pend_reg;
    logic          pend_next;
    logic [W-1:0]  pend_tgt_reg;
    logic [W-1:0]  pend_tgt_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Inertial rules: idle/cancel, (re)start, count down, commit on expiry.
    // A load at edge k leaves D-1 in the counter so the commit lands on edge k+D.
    always_comb begin
        state_next    = state_reg;
        pend_next     = pend_reg;
        pend_tgt_next = pend_tgt_reg;
        cnt_next      = cnt_reg;
        if (target == state_reg) begin
            pend_next = 1'b0;
            cnt_next  = '0;
        end else if (!pend_reg || (target != pend_tgt_reg)) begin
            pend_next     = 1'b1;
            pend_tgt_next = target;
            cnt_next      = delay - CW'(1);
        end else if (cnt_reg == '0) begin
            state_next = pend_tgt_reg;
            pend_next  = 1'b0;
        end else begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    // State, pending target and counter registers; reset discards any pending change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= RESET_STATE;
            pend_reg     <= 1'b0;
            pend_tgt_reg <= RESET_STATE;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pend_reg     <= pend_next;
            pend_tgt_reg <= pend_tgt_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign state      = state_reg;
    // Value the state register takes at this edge, for stages that chain off it.
    assign next_state = rst_n ? state_next : RESET_STATE;

endmodule

// File: rtl/tristate_nand_cycle_model.sv
// Cycle-accurate model of a 4P/4N tri-state NAND: w = ~(a & b) while c = 1,
// high-impedance while c = 0. Transistor delays are whole-cycle inertial delays.
module tristate_nand_cycle_model
    import tnand_pkg::*;
#(
    parameter int P_RISE = DEF_P_RISE,
    parameter int P_FALL = DEF_P_FALL,
    parameter int P_OFF  = DEF_P_OFF,
    parameter int N_RISE = DEF_N_RISE,
    parameter int N_FALL = DEF_N_FALL,
    parameter int N_OFF  = DEF_N_OFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic w_oe,
    output logic w_val,
    output logic i_node
);

    // P_FALL and N_RISE only size the counter: no transition of this cell uses them.
    localparam int CNT_W = $clog2(max_delay(P_RISE, P_FALL, P_OFF,
                                            N_RISE, N_FALL, N_OFF) + 1);

    logic             i_target;
    logic [CNT_W-1:0] i_delay;
    logic             i_state;
    logic             i_next;

    logic             pu_on;
    logic             pd_on;
    w_state_e         w_target;
    w_state_e         w_state;
    logic [1:0]       w_state_bits;
    logic [1:0]       w_next_bits;
    logic [CNT_W-1:0] w_delay;

    // Inverter on c: PMOS pulls i up, NMOS pulls it down.
    always_comb begin
        i_target = ~c;
        i_delay  = i_target ? CNT_W'(P_RISE) : CNT_W'(N_FALL);
    end

    mos_inertial_delay #(
        .W           (1),
        .CW          (CNT_W),
        .RESET_STATE (1'b1)
    ) u_i_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .target     (i_target),
        .delay      (i_delay),
        .state      (i_state),
        .next_state (i_next)
    );

    // Output networks and target selection. The pull-up reads the i node as it
    // is registered at this edge, so the enable path costs exactly the inverter
    // delay plus the output delay with no extra sampling cycle in between.
    always_comb begin
        pu_on = (~a | ~b) & ~i_next;
        pd_on = a & b & c;
        if (pu_on) begin
            w_target = W_ONE;
        end else if (pd_on) begin
            w_target = W_ZERO;
        end else begin
            w_target = W_HIZ;
        end
    end

    // Output delay depends on where the node is going and, for release, where it was.
    always_comb begin
        case (w_target)
            W_ONE:   w_delay = CNT_W'(P_RISE);
            W_ZERO:  w_delay = CNT_W'(N_FALL);
            default: w_delay = (w_state == W_ONE) ? CNT_W'(P_OFF) : CNT_W'(N_OFF);
        endcase
    end

    mos_inertial_delay #(
        .W           (2),
        .CW          (CNT_W),
        .RESET_STATE (W_HIZ)
    ) u_w_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .target     (w_target),
        .delay      (w_delay),
        .state      (w_state_bits),
        .next_state (w_next_bits)
    );

    assign w_state = w_state_e'(w_state_bits);

    // Both stacks conducting would be a supply short; the topology forbids it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(pu_on && pd_on))
                else $error("pull-up and pull-down both on");
        end
    end

    // Output encoding; the value is forced low whenever the node is released.
    always_comb begin
        w_oe   = (w_state != W_HIZ);
        w_val  = (w_state == W_ONE);
        i_node = i_state;
    end

    // The output's own next-state is not needed downstream.
    logic unused_w_next;
    assign unused_w_next = ^w_next_bits;

endmodule

// File: tb/tb_tristate_nand_cycle_model.sv
// Bench for the tri-state NAND cycle model: directed scenarios with explicit
// expectations plus randomized inputs checked against an edge-time reference.
module tb_tristate_nand_cycle_model;

    localparam int T_P_RISE = 4;
    localparam int T_P_OFF  = 9;
    localparam int T_N_FALL = 5;
    localparam int T_N_OFF  = 7;
    localparam int M_ZERO = 0;
    localparam int M_ONE  = 1;
    localparam int M_HIZ  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;
    logic w_oe;
    logic w_val;
    logic i_node;

    int checks = 0;
    int errors = 0;

    // Reference model state: logical node values plus absolute due edges.
    int edge_no = 0;
    int i_st = 1, i_tgt = 1, i_due = 0;
    bit i_pend = 0;
    int w_st = M_HIZ, w_tgt = M_HIZ, w_due = 0;
    bit w_pend = 0;

    tristate_nand_cycle_model dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .w_oe   (w_oe),
        .w_val  (w_val),
        .i_node (i_node)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s at edge %0d observed=%b expected=%b", tag, edge_no, obs, exp);
            end
    endtask

    task automatic dcheck(input string tag, input logic obs, input logic exp);
        $display("step %-12s edge=%0d a=%b b=%b c=%b observed=%b expected=%b",
                 tag, edge_no, a, b, c, obs, exp);
        check(tag, obs, exp);
    endtask

    // A node moves to a new value once that value has been the target for d edges.
    task automatic node_update(inout int st, inout bit pend, inout int tgt, inout int due,
                               input int target, input int d);
        if (target == st) begin
            pend = 0;
        end else if (!pend || target != tgt) begin
            pend = 1;
            tgt  = target;
            due  = edge_no + d;
        end else if (edge_no == due) begin
            st   = tgt;
            pend = 0;
        end
    endtask

    task automatic model_edge();
        int tgt_i;
        int tgt_w;
        int d;
        bit pu;
        bit pd;
        edge_no++;
        if (!rst_n) begin
            i_st = 1; i_pend = 0;
            w_st = M_HIZ; w_pend = 0;
        end else begin
            tgt_i = c ? 0 : 1;
            d = tgt_i == 1 ? T_P_RISE : T_N_FALL;
            node_update(i_st, i_pend, i_tgt, i_due, tgt_i, d);
            pu = (!a || !b) && (i_st == 0);
            pd = a && b && c;
            tgt_w = pu ? M_ONE : (pd ? M_ZERO : M_HIZ);
            if (tgt_w == M_ONE)       d = T_P_RISE;
            else if (tgt_w == M_ZERO) d = T_N_FALL;
            else                      d = (w_st == M_ONE) ? T_P_OFF : T_N_OFF;
            node_update(w_st, w_pend, w_tgt, w_due, tgt_w, d);
        end
    endtask

    // One clock edge: advance the model, then compare just after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_w_oe",  w_oe,   (w_st != M_HIZ));
        check("model_w_val", w_val,  (w_st == M_ONE));
        check("model_i",     i_node, (i_st == 1));
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    initial begin
        // Reset with all inputs low, then hold.
        rst_n = 1'b0; a = 0; b = 0; c = 0;
        ticks(2);
        dcheck("rst_i", i_node, 1'b1);
        dcheck("rst_oe", w_oe, 1'b0);
        dcheck("rst_val", w_val, 1'b0);
        rst_n = 1'b1;
        ticks(20);
        dcheck("idle_oe", w_oe, 1'b0);
        dcheck("idle_i", i_node, 1'b1);

        // Enable: i falls after N_FALL, output rises P_RISE later.
        c = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (t == 4) dcheck("en_i_k4", i_node, 1'b1);
            if (t == 5) dcheck("en_i_k5", i_node, 1'b0);
            if (t == 8) dcheck("en_oe_k8", w_oe, 1'b0);
            if (t == 9) begin
                dcheck("en_oe_k9", w_oe, 1'b1);
                dcheck("en_val_k9", w_val, 1'b1);
            end
        end
        ticks(8);

        // a rises alone: still driven 1; then b rises: falls after N_FALL.
        a = 1'b1;
        ticks(40);
        dcheck("a_only_oe", w_oe, 1'b1);
        dcheck("a_only_val", w_val, 1'b1);
        b = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (t == 4) dcheck("fall_m4", w_val, 1'b1);
            if (t == 5) begin
                dcheck("fall_m5", w_val, 1'b0);
                dcheck("fall_oe_m5", w_oe, 1'b1);
            end
        end
        ticks(5);

        // a and b drop together: rises after P_RISE.
        a = 1'b0; b = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (t == 3) dcheck("rise_n3", w_val, 1'b0);
            if (t == 4) dcheck("rise_n4", w_val, 1'b1);
        end
        ticks(10);

        // Disable from driven 1: i rises after P_RISE, release P_OFF later.
        c = 1'b0;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (t == 3)  dcheck("dis_i_p3", i_node, 1'b0);
            if (t == 4)  dcheck("dis_i_p4", i_node, 1'b1);
            if (t == 12) dcheck("dis_oe_p12", w_oe, 1'b1);
            if (t == 13) dcheck("dis_oe_p13", w_oe, 1'b0);
        end
        ticks(10);

        // Short enable pulse from reset is swallowed by the inverter.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        c = 1'b1;
        ticks(3);
        c = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (t % 5 == 4) begin
                dcheck("pulse_i", i_node, 1'b1);
                dcheck("pulse_oe", w_oe, 1'b0);
            end
        end

        // Reset in the middle of a pending 0 -> 1 output change.
        a = 1'b1; b = 1'b1; c = 1'b1;
        ticks(15);
        dcheck("pre_rst_oe", w_oe, 1'b1);
        dcheck("pre_rst_val", w_val, 1'b0);
        dcheck("pre_rst_i", i_node, 1'b0);
        a = 1'b0;
        ticks(2);
        rst_n = 1'b0; c = 1'b0;
        tick();
        dcheck("mid_rst_oe", w_oe, 1'b0);
        dcheck("mid_rst_val", w_val, 1'b0);
        dcheck("mid_rst_i", i_node, 1'b1);
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (t % 4 == 3) begin
                dcheck("post_rst_oe", w_oe, 1'b0);
                dcheck("post_rst_i", i_node, 1'b1);
            end
        end

        // Randomized inputs with mostly-held values and occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 5) == 0) a = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) c = 1'($urandom_range(0, 1));
            tick();
            $display("rnd cyc=%0d rst_n=%b a=%b b=%b c=%b w_oe=%b w_val=%b i=%b",
                     n, rst_n, a, b, c, w_oe, w_val, i_node);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
